writeback_stage: RTL and testbench
==================================

Name: writeback_stage

Overview:
- MEM/WB pipeline register plus writeback logic. It registers the memory-stage result bundle each clock.
- It formats load data from the synchronous data memory, selects the final writeback value, and drives the register-file write port (we_WB, wr_addr_WB, wr_data_WB).
- It also keeps the retired-instruction counter (instret).

Parameters:
- DATA_WIDTH, 32, datapath width; load extraction assumes 32.
- ADDR_WIDTH, 5, register address width.
- CNT_WIDTH, 64, instret counter width.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset
- valid_MEM  input  1  MEM stage holds a real instruction
- stall_i  input  1  hold MEM/WB register contents
- flush_i  input  1  kill instruction entering WB
- reg_we_MEM  input  1  instruction writes rd
- rd_addr_MEM  input  ADDR_WIDTH  destination register
- wb_sel_MEM  input  2  00=ALU, 01=load, 10=PC+4, 11=immediate
- funct3_MEM  input  3  load size/sign
- alu_result_MEM  input  DATA_WIDTH  ALU result / load address
- pc_plus4_MEM  input  DATA_WIDTH  link value
- imm_MEM  input  DATA_WIDTH  immediate (LUI)
- mem_rdata_WB  input  DATA_WIDTH  raw aligned word from data RAM, valid in WB cycle
- valid_WB  output  1  WB holds a real instruction
- we_WB  output  1  register-file write enable
- wr_addr_WB  output  ADDR_WIDTH  write address
- wr_data_WB  output  DATA_WIDTH  write data
- instret_o  output  CNT_WIDTH  retired-instruction count

Behaviour:
- Reset (rst_n, synchronous, active-low; clock clk):
  - All pipeline registers and instret clear to 0.
  - After reset: valid_WB=0, we_WB=0, wr_addr_WB=0, wr_data_WB=0, instret_o=0.
- Register update priority per clock edge: reset > flush_i > stall_i > load.
  - flush_i=1: valid_q<=0, reg_we_q<=0; other fields don't care. Flush wins over stall.
  - stall_i=1 (no flush): all fields hold.
  - Otherwise: capture all *_MEM inputs; valid_q<=valid_MEM.
- Latency: MEM inputs appear at the WB outputs one cycle later.
- Data RAM timing: RAM read is launched in MEM. mem_rdata_WB is sampled combinationally in the WB cycle and is not registered here.
- Write enable: we_WB = valid_q & reg_we_q & (rd_q != 0). Combinational from registered state.
- wr_addr_WB = rd_q.
- wr_data_WB = 0 whenever we_WB=0. Otherwise, by wb_sel_q:
  - 00 → alu_q
  - 01 → load value
  - 10 → pc4_q
  - 11 → imm_q
- Load formatting, off = alu_q[1:0]:
  - funct3 000 LB: byte mem_rdata_WB[8*off+7:8*off], sign-extended.
  - funct3 100 LBU: same byte, zero-extended.
  - funct3 001 LH: half selected by off[1] (off[0] ignored; misaligned access unsupported), sign-extended.
  - funct3 101 LHU: same half, zero-extended.
  - funct3 010, 011, 110, 111: full word; offset ignored.
- instret:
  - Increments by 1 at each edge where valid_q=1 and stall_i=0 (the instruction leaves WB). Flush does not block this count.
  - A stalled instruction is counted once.
  - Wraps modulo 2^CNT_WIDTH with no saturation.
- Outputs are purely registered-state driven, except the load path, which depends on mem_rdata_WB.
- Reset mid-stall or mid-flush: reset wins; the next cycle shows all outputs 0.

Test Plan:
- Reset, then valid_MEM=1, reg_we=1, rd=5, wb_sel=00, alu=0x1234 → next cycle: we_WB=1, wr_addr_WB=5, wr_data_WB=0x00001234, valid_WB=1. The following cycle: instret_o=1.
- Load, mem_rdata_WB=0x80FF7F01:
  - LB off=3 → 0xFFFFFF80
  - LBU off=1 → 0x0000007F
  - LH off=2 → 0xFFFF80FF
  - LHU off=0 → 0x00007F01
  - LW off=2 → 0x80FF7F01
- rd=0 with reg_we=1, wb_sel=10, pc4=0x104 → we_WB=0, wr_data_WB=0. instret still increments.
- stall_i=1 for 3 cycles with a valid rd=7 instruction in WB → outputs stable for 4 cycles, MEM changes ignored, instret +1 total.
- flush_i=1 together with stall_i=1 → next cycle: valid_WB=0, we_WB=0. The prior valid WB instruction is counted only if stall_i=0.
- Preload via long run: after 2^16 valid back-to-back instructions, instret_o=0x10000. Assert rst_n=0 mid-stream → all outputs 0 on the next cycle.

Source files
------------

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register and writeback: formats load data from the data RAM,
// selects the register-file write value and counts retired instructions.
module writeback_stage #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned CNT_WIDTH  = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid_MEM,
    input  logic                  stall_i,
    input  logic                  flush_i,
    input  logic                  reg_we_MEM,
    input  logic [ADDR_WIDTH-1:0] rd_addr_MEM,
    input  logic [1:0]            wb_sel_MEM,
    input  logic [2:0]            funct3_MEM,
    input  logic [DATA_WIDTH-1:0] alu_result_MEM,
    input  logic [DATA_WIDTH-1:0] pc_plus4_MEM,
    input  logic [DATA_WIDTH-1:0] imm_MEM,
    input  logic [DATA_WIDTH-1:0] mem_rdata_WB,
    output logic                  valid_WB,
    output logic                  we_WB,
    output logic [ADDR_WIDTH-1:0] wr_addr_WB,
    output logic [DATA_WIDTH-1:0] wr_data_WB,
    output logic [CNT_WIDTH-1:0]  instret_o
);

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned HALF_W = 16;

    logic                  r_valid;
    logic                  r_reg_we;
    logic [ADDR_WIDTH-1:0] r_rd;
    logic [1:0]            r_wb_sel;
    logic [2:0]            r_funct3;
    logic [DATA_WIDTH-1:0] r_alu;
    logic [DATA_WIDTH-1:0] r_pc4;
    logic [DATA_WIDTH-1:0] r_imm;
    logic [CNT_WIDTH-1:0]  r_instret;

    logic [BYTE_W-1:0]     w_byte;
    logic [HALF_W-1:0]     w_half;
    logic [DATA_WIDTH-1:0] w_load;
    logic                  w_we;

    // Pipeline register: flush beats stall; an instruction retires when it leaves WB unstalled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid   <= 1'b0;
            r_reg_we  <= 1'b0;
            r_rd      <= '0;
            r_wb_sel  <= '0;
            r_funct3  <= '0;
            r_alu     <= '0;
            r_pc4     <= '0;
            r_imm     <= '0;
            r_instret <= '0;
        end else begin
            if (r_valid && !stall_i) begin
                r_instret <= r_instret + CNT_WIDTH'(1);
            end
            if (flush_i) begin
                r_valid  <= 1'b0;
                r_reg_we <= 1'b0;
            end else if (!stall_i) begin
                r_valid  <= valid_MEM;
                r_reg_we <= reg_we_MEM;
                r_rd     <= rd_addr_MEM;
                r_wb_sel <= wb_sel_MEM;
                r_funct3 <= funct3_MEM;
                r_alu    <= alu_result_MEM;
                r_pc4    <= pc_plus4_MEM;
                r_imm    <= imm_MEM;
            end
        end
    end

    // Load lane extraction; a halfword ignores the low offset bit.
    always_comb begin
        w_byte = mem_rdata_WB[{r_alu[1:0], 3'b000} +: BYTE_W];
        w_half = mem_rdata_WB[{r_alu[1], 4'b0000} +: HALF_W];
        case (r_funct3)
            3'b000:  w_load = {{(DATA_WIDTH-BYTE_W){w_byte[BYTE_W-1]}}, w_byte};
            3'b100:  w_load = {{(DATA_WIDTH-BYTE_W){1'b0}}, w_byte};
            3'b001:  w_load = {{(DATA_WIDTH-HALF_W){w_half[HALF_W-1]}}, w_half};
            3'b101:  w_load = {{(DATA_WIDTH-HALF_W){1'b0}}, w_half};
            default: w_load = mem_rdata_WB;
        endcase
    end

    assign w_we = r_valid & r_reg_we & (r_rd != '0);

    // Writeback mux; data is forced to zero when no write happens.
    always_comb begin
        wr_data_WB = '0;
        if (w_we) begin
            case (r_wb_sel)
                2'b00:   wr_data_WB = r_alu;
                2'b01:   wr_data_WB = w_load;
                2'b10:   wr_data_WB = r_pc4;
                default: wr_data_WB = r_imm;
            endcase
        end
    end

    assign valid_WB   = r_valid;
    assign we_WB      = w_we;
    assign wr_addr_WB = r_rd;
    assign instret_o  = r_instret;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed self-checking bench for writeback_stage.
module tb_writeback_stage;

    logic        clk;
    logic        rst_n;
    logic        valid_MEM;
    logic        stall_i;
    logic        flush_i;
    logic        reg_we_MEM;
    logic [4:0]  rd_addr_MEM;
    logic [1:0]  wb_sel_MEM;
    logic [2:0]  funct3_MEM;
    logic [31:0] alu_result_MEM;
    logic [31:0] pc_plus4_MEM;
    logic [31:0] imm_MEM;
    logic [31:0] mem_rdata_WB;
    logic        valid_WB;
    logic        we_WB;
    logic [4:0]  wr_addr_WB;
    logic [31:0] wr_data_WB;
    logic [63:0] instret_o;

    int unsigned n_checks;
    int unsigned n_errors;
    logic        m_valid;
    logic [63:0] m_cnt;

    writeback_stage #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .CNT_WIDTH(64)) dut (
        .clk(clk), .rst_n(rst_n), .valid_MEM(valid_MEM), .stall_i(stall_i),
        .flush_i(flush_i), .reg_we_MEM(reg_we_MEM), .rd_addr_MEM(rd_addr_MEM),
        .wb_sel_MEM(wb_sel_MEM), .funct3_MEM(funct3_MEM),
        .alu_result_MEM(alu_result_MEM), .pc_plus4_MEM(pc_plus4_MEM),
        .imm_MEM(imm_MEM), .mem_rdata_WB(mem_rdata_WB), .valid_WB(valid_WB),
        .we_WB(we_WB), .wr_addr_WB(wr_addr_WB), .wr_data_WB(wr_data_WB),
        .instret_o(instret_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Advance one edge; a tiny retire-count model tracks what instret should read.
    task automatic tick();
        if (!rst_n) begin
            m_valid = 1'b0;
            m_cnt   = '0;
        end else begin
            if (m_valid && !stall_i) m_cnt = m_cnt + 64'd1;
            if (flush_i)       m_valid = 1'b0;
            else if (!stall_i) m_valid = valid_MEM;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic we, input logic [4:0] rd,
                         input logic [1:0] sel, input logic [2:0] f3, input logic [31:0] alu,
                         input logic [31:0] pc4, input logic [31:0] imm);
        valid_MEM      = v;
        reg_we_MEM     = we;
        rd_addr_MEM    = rd;
        wb_sel_MEM     = sel;
        funct3_MEM     = f3;
        alu_result_MEM = alu;
        pc_plus4_MEM   = pc4;
        imm_MEM        = imm;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid"}, 64'(valid_WB), 64'd0);
        check({tag, "_we"}, 64'(we_WB), 64'd0);
        check({tag, "_addr"}, 64'(wr_addr_WB), 64'd0);
        check({tag, "_data"}, 64'(wr_data_WB), 64'd0);
        check({tag, "_instret"}, instret_o, 64'd0);
    endtask

    initial begin
        logic [2:0]  ld_f3  [5];
        logic [1:0]  ld_off [5];
        logic [31:0] ld_exp [5];
        n_checks = 0;
        n_errors = 0;
        m_valid  = 1'b0;
        m_cnt    = '0;
        ld_f3  = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
        ld_off = '{2'd3, 2'd1, 2'd2, 2'd0, 2'd2};
        ld_exp = '{32'hFFFFFF80, 32'h0000007F, 32'hFFFF80FF, 32'h00007F01, 32'h80FF7F01};

        rst_n = 1'b0; stall_i = 1'b0; flush_i = 1'b0; mem_rdata_WB = '0;
        drive(1'b0, 1'b0, 5'd0, 2'd0, 3'd0, 32'd0, 32'd0, 32'd0);
        tick(); tick();
        check_zero("reset");

        // Basic ALU writeback
        rst_n = 1'b1;
        drive(1'b1, 1'b1, 5'd5, 2'b00, 3'd0, 32'h1234, 32'h0, 32'h0);
        tick();
        check("alu_we", 64'(we_WB), 64'd1);
        check("alu_addr", 64'(wr_addr_WB), 64'd5);
        check("alu_data", 64'(wr_data_WB), 64'h1234);
        check("alu_valid", 64'(valid_WB), 64'd1);
        check("alu_instret0", instret_o, 64'd0);
        drive(1'b0, 1'b0, 5'd0, 2'd0, 3'd0, 32'd0, 32'd0, 32'd0);
        tick();
        check("alu_instret1", instret_o, 64'd1);
        check("bubble_valid", 64'(valid_WB), 64'd0);

        // Load formatting
        mem_rdata_WB = 32'h80FF7F01;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b1, 5'd10, 2'b01, ld_f3[i], 32'h1000 | 32'(ld_off[i]), 32'h0, 32'h0);
            tick();
            check($sformatf("load%0d_data", i), 64'(wr_data_WB), 64'(ld_exp[i]));
        end
        check("load_instret", instret_o, 64'd5);

        // Immediate select
        drive(1'b1, 1'b1, 5'd12, 2'b11, 3'd0, 32'h0, 32'h0, 32'hDEAD0000);
        tick();
        check("imm_data", 64'(wr_data_WB), 64'hDEAD0000);

        // rd=0 suppresses the write but still retires
        drive(1'b1, 1'b1, 5'd0, 2'b10, 3'd0, 32'h0, 32'h104, 32'h0);
        tick();
        check("x0_we", 64'(we_WB), 64'd0);
        check("x0_data", 64'(wr_data_WB), 64'd0);
        check("x0_valid", 64'(valid_WB), 64'd1);
        drive(1'b0, 1'b0, 5'd0, 2'd0, 3'd0, 32'd0, 32'd0, 32'd0);
        tick();
        check("x0_instret", instret_o, 64'd8);

        // Stall holds the WB instruction for 4 cycles and retires it once
        drive(1'b1, 1'b1, 5'd7, 2'b00, 3'd0, 32'hABCD, 32'h0, 32'h0);
        tick();
        stall_i = 1'b1;
        drive(1'b1, 1'b1, 5'd9, 2'b10, 3'd0, 32'h5555, 32'h2222, 32'h0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("stall%0d_addr", i), 64'(wr_addr_WB), 64'd7);
            check($sformatf("stall%0d_data", i), 64'(wr_data_WB), 64'hABCD);
            check($sformatf("stall%0d_instret", i), instret_o, 64'd8);
            if (i < 3) tick();
        end
        stall_i = 1'b0;
        drive(1'b0, 1'b0, 5'd0, 2'd0, 3'd0, 32'd0, 32'd0, 32'd0);
        tick();
        check("stall_instret", instret_o, 64'd9);

        // Flush with stall: killed, not counted
        drive(1'b1, 1'b1, 5'd3, 2'b00, 3'd0, 32'h33, 32'h0, 32'h0);
        tick();
        flush_i = 1'b1; stall_i = 1'b1;
        tick();
        check("flst_valid", 64'(valid_WB), 64'd0);
        check("flst_we", 64'(we_WB), 64'd0);
        check("flst_instret", instret_o, 64'd9);
        // Flush without stall: killed, prior instruction counted
        flush_i = 1'b0; stall_i = 1'b0;
        tick();
        flush_i = 1'b1;
        tick();
        check("fl_valid", 64'(valid_WB), 64'd0);
        check("fl_instret", instret_o, 64'd10);
        check("model_instret", instret_o, m_cnt);
        flush_i = 1'b0;

        // Long run from reset: 65537 loads, 65536 retirements
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        drive(1'b1, 1'b1, 5'd1, 2'b00, 3'd0, 32'h1, 32'h0, 32'h0);
        for (int i = 0; i < 65537; i++) tick();
        check("long_instret", instret_o, 64'h10000);
        check("long_model", instret_o, m_cnt);

        // Reset mid-stall/flush wins
        stall_i = 1'b1; flush_i = 1'b1; rst_n = 1'b0;
        tick();
        check_zero("midrst");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
